// File: rtl/cpa_chunked_pkg.sv
// Shared types and sizing helpers for the chunked carry-propagate adder.
package cpa_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CHUNK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_bits(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpa_chunk_adder.sv
// CHUNK-bit ripple of full-adder counters, plus the 3:2 counter cell itself.
module counter_3_2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

module cpa_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;
    assign co   = c[CHUNK];

    for (genvar g = 0; g < CHUNK; g++) begin : g_bit
        counter_3_2 u_cnt (
            .a  (a[g]),
            .b  (b[g]),
            .c  (c[g]),
            .s  (s[g]),
            .co (c[g+1])
        );
    end

endmodule

// File: rtl/cpa_chunked.sv
// Multi-cycle carry-propagate adder resolving CHUNK bits per cycle.
// Optional accumulator third addend: define CPA_CHUNKED_ACCUM_EN.
module cpa_chunked
    import cpa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
`ifdef CPA_CHUNKED_ACCUM_EN
    input  logic             in_acc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_bits(WIDTH, CHUNK);

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_top;
    logic [WIDTH:0]   result;

    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_top;

`ifdef CPA_CHUNKED_ACCUM_EN
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] acc_row;
    logic [WIDTH-1:0] row_s;
    logic [WIDTH-1:0] row_c;

    assign acc_row = in_acc ? acc[WIDTH-1:0] : '0;

    for (genvar g = 0; g < WIDTH; g++) begin : g_row
        counter_3_2 u_row (
            .a  (in_sum[g]),
            .b  (in_carry[g]),
            .c  (acc_row[g]),
            .s  (row_s[g]),
            .co (row_c[g])
        );
    end

    // Top carry-row bit lands at weight 2^WIDTH, folded in at the last chunk.
    assign cap_a   = row_s;
    assign cap_b   = {row_c[WIDTH-2:0], 1'b0};
    assign cap_top = row_c[WIDTH-1];
`else
    assign cap_a   = in_sum;
    assign cap_b   = in_carry;
    assign cap_top = 1'b0;
`endif

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] s_ch;
    logic             co_ch;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                a_ch = op_a[k*CHUNK +: CHUNK];
                b_ch = op_b[k*CHUNK +: CHUNK];
            end
        end
    end

    cpa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_add (
        .a  (a_ch),
        .b  (b_ch),
        .ci (carry),
        .s  (s_ch),
        .co (co_ch)
    );

    assign in_ready   = (state == IDLE) && !rst;
    assign out_result = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_top    <= 1'b0;
`ifdef CPA_CHUNKED_ACCUM_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a   <= cap_a;
                        op_b   <= cap_b;
                        op_top <= cap_top;
                        idx    <= '0;
                        carry  <= 1'b0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IW'(k)) begin
                            result[k*CHUNK +: CHUNK] <= s_ch;
                        end
                    end
                    carry <= co_ch;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(NCHUNK - 1)) begin
                        result[WIDTH] <= co_ch ^ op_top;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef CPA_CHUNKED_ACCUM_EN
                        acc       <= result;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpa_chunked.sv
// Randomized bench for cpa_chunked against an arithmetic reference model.
module tb_cpa_chunked;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_result;
`ifdef CPA_CHUNKED_ACCUM_EN
    logic             in_acc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH:0] model_acc;

    always #5 clk = ~clk;

    cpa_chunked #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
`ifdef CPA_CHUNKED_ACCUM_EN
        .in_acc     (in_acc),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input bit use_acc);
        int unsigned t;
        t = a + b;
        if (use_acc) t = t + model_acc[WIDTH-1:0];
        return t[WIDTH:0];
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic handshake(input logic [WIDTH:0] res);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        model_acc = res;
    endtask

    task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit use_acc, input string tag);
        logic [WIDTH:0] exp;
        int lat;
        int w;
`ifdef CPA_CHUNKED_ACCUM_EN
        exp    = model(a, b, use_acc);
        in_acc = use_acc;
`else
        exp = model(a, b, 1'b0);
`endif
        in_sum   = a;
        in_carry = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick;
            w++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        in_sum   = WIDTH'($urandom);
        in_carry = WIDTH'($urandom);
`ifdef CPA_CHUNKED_ACCUM_EN
        in_acc   = 1'($urandom);
`endif
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(NCHUNK));
        check({tag, "_res"}, 32'(out_result), 32'(exp));
        handshake(exp);
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
`ifdef CPA_CHUNKED_ACCUM_EN
        in_acc = 1'b0;
`endif
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_in_ready2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        model_acc = '0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH:0] exp_q[$];
        int acc_cyc[$];
        logic [WIDTH:0] e;
        int lat;
        int got;
        int sent;
        bit took;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b0;
        model_acc = '0;
`ifdef CPA_CHUNKED_ACCUM_EN
        in_acc    = 1'b0;
`endif
        tick;
        do_reset;

        do_txn(16'h00FF, 16'h0001, 1'b0, "small");
        do_txn(16'hFFFF, 16'hFFFF, 1'b0, "allones");
        do_txn(16'hFFFF, 16'h0001, 1'b0, "ripple");

        // Backpressure with new data waiting on the input side.
        in_sum   = 16'h0F0F;
        in_carry = 16'h00F1;
        in_valid = 1'b1;
        e = model(16'h0F0F, 16'h00F1, 1'b0);
        tick;
        in_sum   = 16'hAAAA;
        in_carry = 16'h5555;
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'(NCHUNK));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_res", 32'(out_result), 32'(e));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick;
        end
        handshake(e);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        e = model(16'hAAAA, 16'h5555, 1'b0);
        tick;
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_next_lat", 32'(lat), 32'(NCHUNK));
        check("bp_next_res", 32'(out_result), 32'(e));
        handshake(e);

        // Abandon a transaction in its second ADD cycle.
        in_sum   = 16'h1111;
        in_carry = 16'h2222;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        do_reset;
        do_txn(16'h1234, 16'h4321, 1'b0, "post_rst");

        // Back-to-back with both handshakes tied high.
        sent = 0;
        got  = 0;
        in_sum    = WIDTH'($urandom);
        in_carry  = WIDTH'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back(model(in_sum, in_carry, 1'b0));
                acc_cyc.push_back(c);
                sent++;
            end
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_res", 32'(out_result), 32'(e));
                    model_acc = e;
                end else begin
                    check("b2b_spurious", 32'(out_valid), 32'd0);
                end
                got++;
            end
            tick;
            if (took) begin
                if (sent == 3) begin
                    in_valid = 1'b0;
                end else begin
                    in_sum   = WIDTH'($urandom);
                    in_carry = WIDTH'($urandom);
                end
            end
        end
        out_ready = 1'b0;
        check("b2b_count", 32'(got), 32'd3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NCHUNK + 2));
            check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(NCHUNK + 2));
        end else begin
            check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        end
        tick;

        for (int i = 0; i < 20; i++) begin
            do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");
        end

`ifdef CPA_CHUNKED_ACCUM_EN
        do_reset;
        do_txn(16'h0010, 16'h0000, 1'b0, "acc_load");
        do_txn(16'h0005, 16'h0003, 1'b1, "acc_add");
        check("acc_add_val", 32'(model_acc), 32'h18);
        do_reset;
        do_txn(16'h0001, 16'h0000, 1'b1, "acc_cleared");
        for (int i = 0; i < 10; i++) begin
            do_txn(WIDTH'($urandom), WIDTH'($urandom), 1'b1, "acc_rand");
        end
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cpa_chunked.md
Name: cpa_chunked

Overview:
- Multi-cycle carry-propagate adder. It sits directly downstream of the 3:2 / 7:3 counter reduction tree.
- It accepts the final two equal-weight rows produced by the tree, sum and carry, and resolves them into one binary result.
- It adds CHUNK bits per cycle using a rippled chain of 3:2 counters, trading latency for area.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 16, width of each input row; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK must be at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand rows are valid.
- in_ready  output  1  block can accept operands.
- in_sum  input  WIDTH  sum row from the tree.
- in_carry  input  WIDTH  carry row, already aligned to the same bit weights as in_sum.
- out_valid  output  1  out_result is valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH+1  in_sum + in_carry, with bit WIDTH as the final carry.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE; chunk index, running carry and the result register are cleared to 0.
  - out_valid = 0 and out_result = 0.
  - in_ready is forced to 0 in any cycle where rst is high.
- States:
  - IDLE: in_ready = 1 and out_valid = 0. On in_valid && in_ready, capture in_sum/in_carry into operand registers, clear the index and carry, and go to ADD.
  - ADD: each edge adds operand chunk[idx] of both rows plus the running carry, writes the CHUNK sum bits into result[idx*CHUNK +: CHUNK], updates the carry and increments idx. When the edge processes idx == NCHUNK-1, it writes result[WIDTH] = carry-out and goes to DONE. in_ready = 0 throughout.
  - DONE: out_valid = 1 and in_ready = 0. On out_ready, go to IDLE.
- Latency and throughput:
  - out_valid rises exactly NCHUNK cycles after the acceptance edge.
  - Minimum initiation interval is NCHUNK+2 cycles when out_ready is held high.
- Output hold:
  - out_result and out_valid stay stable while out_valid && !out_ready.
  - out_result is don't-care while out_valid = 0.
- Input hold: in_sum/in_carry are sampled only at the acceptance edge; later changes are ignored.
- Reset mid-operation (ADD or DONE): the transaction is abandoned and no result is emitted. The block is back in IDLE on the edge after rst deasserts.
- Carry across chunks: the carry ripples to the top chunk; 0xFFFF + 0x0001 must produce 0x10000.

Optional Feature:
- Macro: CPA_CHUNKED_ACCUM_EN.
- With the macro defined:
  - Adds input port in_acc (1 bit), sampled at the acceptance edge, and an accumulator register (WIDTH+1 bits, reset to 0).
  - When in_acc = 1, the accumulator's low WIDTH bits form a third addend. At capture, a row of 3:2 counters reduces sum/carry/acc to two rows.
  - Result = (in_sum + in_carry + acc) mod 2^(WIDTH+1). Latency is unchanged.
  - The accumulator is loaded with out_result at each output handshake.
  - When in_acc = 0, behaviour is identical to the macro-undefined build.
- Without the macro: no in_acc port and no accumulator.

Decomposition:
- Package cpa_pkg holds:
  - the state enum typedef (IDLE, ADD, DONE);
  - default WIDTH/CHUNK constants;
  - an NCHUNK/index-width helper function.
- One natural sub-module, cpa_chunk_adder: a combinational CHUNK-bit ripple of counter_3_2 instances with carry in and carry out. It is instantiated once and muxed by idx.

Test Plan:
- WIDTH=16, CHUNK=4: in_sum=0x00FF, in_carry=0x0001, out_ready=1 -> out_result=0x00100, out_valid high exactly 4 cycles after acceptance for 1 cycle.
- 0xFFFF + 0xFFFF -> out_result=0x1FFFE; then 0xFFFF + 0x0001 -> 0x10000, confirming the carry crosses all chunk boundaries.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid held high and new data presented -> out_result stable, in_ready=0, nothing accepted; one cycle after out_ready=1, in_ready=1.
- Reset on the 2nd ADD cycle -> next cycle out_valid=0 and in_ready=0 while rst is high, then 1 after release; new operands 0x1234 + 0x4321 -> 0x05555.
- Back-to-back: in_valid and out_ready tied high with 3 transactions -> accepts spaced exactly 6 cycles apart, results in order.
- CPA_CHUNKED_ACCUM_EN defined:
  - 0x0010 + 0x0000, in_acc=0 -> 0x00010.
  - then 0x0005 + 0x0003, in_acc=1 -> 0x00018.
  - then rst followed by 0x0001 + 0x0000, in_acc=1 -> 0x00001.
